// File: rtl/nav_pkg.sv
// Heading codes, FSM states and rotation helpers shared by the wall-follower
// and the movement unit's orientation decode.
package nav_pkg;

    localparam logic [2:0] ORI_N = 3'b001;
    localparam logic [2:0] ORI_O = 3'b010;
    localparam logic [2:0] ORI_L = 3'b011;
    localparam logic [2:0] ORI_S = 3'b100;

    // Right turns in a row without an advance that mark an enclosed cell.
    localparam logic [2:0] GIROS_TRAP = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SENSE,
        ST_TURN_L,
        ST_TURN_R,
        ST_ADVANCE,
        ST_WAIT_DONE,
        ST_FINISHED,
        ST_ERRO
    } nav_state_t;

    // Counter-clockwise quarter turn; unknown codes recover to North.
    function automatic logic [2:0] gira_esq(input logic [2:0] ori);
        case (ori)
            ORI_N:   return ORI_O;
            ORI_O:   return ORI_S;
            ORI_S:   return ORI_L;
            ORI_L:   return ORI_N;
            default: return ORI_N;
        endcase
    endfunction

    // Clockwise quarter turn; unknown codes recover to North.
    function automatic logic [2:0] gira_dir(input logic [2:0] ori);
        case (ori)
            ORI_N:   return ORI_L;
            ORI_L:   return ORI_S;
            ORI_S:   return ORI_O;
            ORI_O:   return ORI_N;
            default: return ORI_N;
        endcase
    endfunction

endpackage

// File: rtl/navegador_parede.sv
// Left-hand wall-follower sequencing the avanco movement unit.
// Optional step budget enabled by defining NAV_STEP_LIMIT_EN.
module navegador_parede
    import nav_pkg::*;
#(
    parameter int         W_PASSOS    = 8,
    parameter logic [2:0] ORIENT_INIT = 3'b001,
    parameter int         MAX_PASSOS  = 200
) (
    input  logic                clockc3,
    input  logic                reset,
    input  logic                start,
    input  logic                sensor_valid,
    input  logic                parede_frente,
    input  logic                parede_esq,
    input  logic                chegou,
    input  logic                mov_done,
    output logic                avancar,
    output logic [2:0]          orientacao,
    output logic [W_PASSOS-1:0] passos,
    output logic                busy,
    output logic                concluido,
    output logic                erro
);

    nav_state_t          state_q, state_d;
    logic [2:0]          ori_q, ori_d;
    logic [W_PASSOS-1:0] passos_q, passos_d;
    logic                conc_q, conc_d;
    logic                erro_q, erro_d;
    logic                virou_q, virou_d;
    logic [2:0]          giros_q, giros_d;
    logic                avancar_q, avancar_d;
    logic [W_PASSOS-1:0] passos_inc;

    assign passos_inc = passos_q + 1'b1;

`ifndef NAV_STEP_LIMIT_EN
    localparam int unused_max_passos = MAX_PASSOS;
`endif

    // NOTE: every variable gets its hold value first, so no branch can infer a latch.
    always_comb begin
        state_d  = state_q;
        ori_d    = ori_q;
        passos_d = passos_q;
        conc_d   = conc_q;
        erro_d   = erro_q;
        virou_d  = virou_q;
        giros_d  = giros_q;

        case (state_q)
            ST_IDLE, ST_FINISHED, ST_ERRO: begin
                if (start) begin
                    state_d  = ST_SENSE;
                    passos_d = '0;
                    conc_d   = 1'b0;
                    erro_d   = 1'b0;
                    giros_d  = '0;
                    virou_d  = 1'b0;
                end
            end
            ST_SENSE: begin
                if (sensor_valid) begin
                    if (chegou) begin
                        state_d = ST_FINISHED;
                        conc_d  = 1'b1;
                    end else if (!parede_esq && !virou_q) begin
                        // Heading updates on the decision edge so it is visible one cycle later.
                        state_d = ST_TURN_L;
                        ori_d   = gira_esq(ori_q);
                        virou_d = 1'b1;
                        giros_d = '0;
                    end else if (!parede_frente) begin
                        state_d = ST_ADVANCE;
                    end else begin
                        state_d = ST_TURN_R;
                        ori_d   = gira_dir(ori_q);
                        giros_d = giros_q + 3'd1;
                    end
                end
            end
            ST_TURN_L: state_d = ST_SENSE;
            ST_TURN_R: begin
                if (giros_q == GIROS_TRAP) begin
                    state_d = ST_ERRO;
                    erro_d  = 1'b1;
                end else begin
                    state_d = ST_SENSE;
                end
            end
            ST_ADVANCE: state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (mov_done) begin
                    state_d = ST_SENSE;
                    if (passos_q != '1) passos_d = passos_inc;
                    virou_d = 1'b0;
                    giros_d = '0;
`ifdef NAV_STEP_LIMIT_EN
                    if (passos_q != '1 && passos_inc == W_PASSOS'(MAX_PASSOS)) begin
                        state_d = ST_ERRO;
                        erro_d  = 1'b1;
                    end
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign avancar_d = (state_d == ST_ADVANCE) || (state_d == ST_WAIT_DONE);

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clockc3 or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ori_q     <= ORIENT_INIT;
            passos_q  <= '0;
            conc_q    <= 1'b0;
            erro_q    <= 1'b0;
            virou_q   <= 1'b0;
            giros_q   <= '0;
            avancar_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ori_q     <= ori_d;
            passos_q  <= passos_d;
            conc_q    <= conc_d;
            erro_q    <= erro_d;
            virou_q   <= virou_d;
            giros_q   <= giros_d;
            avancar_q <= avancar_d;
        end
    end

    assign avancar    = avancar_q;
    assign orientacao = ori_q;
    assign passos     = passos_q;
    assign concluido  = conc_q;
    assign erro       = erro_q;
    assign busy       = !((state_q == ST_IDLE) || (state_q == ST_FINISHED) || (state_q == ST_ERRO));

endmodule

// File: tb/tb_navegador_parede.sv
// Scoreboard bench for navegador_parede: stimulus queues expected outputs,
// a negedge monitor pops and compares them.
module tb_navegador_parede;

`ifdef NAV_STEP_LIMIT_EN
    localparam int TB_MAX = 3;
`else
    localparam int TB_MAX = 200;
`endif

    logic       clockc3 = 1'b0;
    logic       reset, start, sensor_valid, parede_frente, parede_esq, chegou, mov_done;
    logic       avancar, busy, concluido, erro;
    logic [2:0] orientacao;
    logic [7:0] passos;

    navegador_parede #(.W_PASSOS(8), .ORIENT_INIT(3'b001), .MAX_PASSOS(TB_MAX)) dut (
        .clockc3(clockc3), .reset(reset), .start(start), .sensor_valid(sensor_valid),
        .parede_frente(parede_frente), .parede_esq(parede_esq), .chegou(chegou),
        .mov_done(mov_done), .avancar(avancar), .orientacao(orientacao),
        .passos(passos), .busy(busy), .concluido(concluido), .erro(erro)
    );

    always #5 clockc3 = ~clockc3;

    typedef struct {
        string       name;
        logic [14:0] v;   // {avancar, orientacao, passos, busy, concluido, erro}
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [14:0] got, input logic [14:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got av=%b ori=%b passos=%0d busy=%b conc=%b erro=%b | want av=%b ori=%b passos=%0d busy=%b conc=%b erro=%b",
                     name, got[14], got[13:11], got[10:3], got[2], got[1], got[0],
                     want[14], want[13:11], want[10:3], want[2], want[1], want[0]);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clockc3);
            while (q.size() > 0) begin
                e = q.pop_front();
                check(e.name, {avancar, orientacao, passos, busy, concluido, erro}, e.v);
            end
        end
    end

    task automatic expect_out(input string name, input logic av, input logic [2:0] ori,
                              input logic [7:0] pas, input logic bsy, input logic conc, input logic err);
        exp_t e;
        e.name = name;
        e.v    = {av, ori, pas, bsy, conc, err};
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clockc3);
        #1;
    endtask

    task automatic sense(input logic esq, input logic frente, input logic goal);
        sensor_valid  = 1'b1;
        parede_esq    = esq;
        parede_frente = frente;
        chegou        = goal;
        tick();
        sensor_valid  = 1'b0;
        parede_esq    = 1'b0;
        parede_frente = 1'b0;
        chegou        = 1'b0;
    endtask

    task automatic finish_move();
        mov_done = 1'b1;
        tick();
        mov_done = 1'b0;
    endtask

    initial begin : stim
        int n_adv;
        reset = 1'b1; start = 1'b0; sensor_valid = 1'b0; parede_frente = 1'b0;
        parede_esq = 1'b0; chegou = 1'b0; mov_done = 1'b0;

        tick();
        expect_out("reset_state", 1'b0, 3'b001, 8'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();

        // Straight advance with a start pulse ignored mid-move.
        start = 1'b1; tick(); start = 1'b0;
        expect_out("start_busy", 1'b0, 3'b001, 8'd0, 1'b1, 1'b0, 1'b0);
        sense(1'b1, 1'b0, 1'b0);
        expect_out("adv_latency", 1'b1, 3'b001, 8'd0, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        expect_out("adv_held", 1'b1, 3'b001, 8'd0, 1'b1, 1'b0, 1'b0);
        start = 1'b1; tick(); start = 1'b0;
        expect_out("start_ignored", 1'b1, 3'b001, 8'd0, 1'b1, 1'b0, 1'b0);
        finish_move();
        expect_out("adv_done", 1'b0, 3'b001, 8'd1, 1'b1, 1'b0, 1'b0);

        // Left turn, then no second left turn before an advance.
        sense(1'b0, 1'b0, 1'b0);
        expect_out("turn_left", 1'b0, 3'b010, 8'd1, 1'b1, 1'b0, 1'b0);
        tick();
        sense(1'b0, 1'b0, 1'b0);
        expect_out("no_2nd_left", 1'b1, 3'b010, 8'd1, 1'b1, 1'b0, 1'b0);
        tick();
        finish_move();
        expect_out("adv2_done", 1'b0, 3'b010, 8'd2, 1'b1, 1'b0, 1'b0);

        // Enclosed cell: four right turns from O, then trap.
        sense(1'b1, 1'b1, 1'b0);
        expect_out("turn_r1", 1'b0, 3'b001, 8'd2, 1'b1, 1'b0, 1'b0);
        tick();
        sense(1'b1, 1'b1, 1'b0);
        expect_out("turn_r2", 1'b0, 3'b011, 8'd2, 1'b1, 1'b0, 1'b0);
        tick();
        sense(1'b1, 1'b1, 1'b0);
        expect_out("turn_r3", 1'b0, 3'b100, 8'd2, 1'b1, 1'b0, 1'b0);
        tick();
        sense(1'b1, 1'b1, 1'b0);
        expect_out("turn_r4", 1'b0, 3'b010, 8'd2, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("trap_erro", 1'b0, 3'b010, 8'd2, 1'b0, 1'b0, 1'b1);

        // Restart from ERRO, then goal beats the open left wall.
        start = 1'b1; tick(); start = 1'b0;
        expect_out("restart_clear", 1'b0, 3'b010, 8'd0, 1'b1, 1'b0, 1'b0);
        sense(1'b0, 1'b0, 1'b1);
        expect_out("goal", 1'b0, 3'b010, 8'd0, 1'b0, 1'b1, 1'b0);
        tick();
        expect_out("goal_sticky", 1'b0, 3'b010, 8'd0, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset pulse between clock edges while waiting for mov_done.
        start = 1'b1; tick(); start = 1'b0;
        sense(1'b1, 1'b0, 1'b0);
        expect_out("pre_reset_adv", 1'b1, 3'b010, 8'd0, 1'b1, 1'b0, 1'b0);
        tick();
        @(negedge clockc3);
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        expect_out("async_reset", 1'b0, 3'b001, 8'd0, 1'b0, 1'b0, 1'b0);
        tick();

        // Open corridor: step budget or saturation.
        start = 1'b1; tick(); start = 1'b0;
`ifdef NAV_STEP_LIMIT_EN
        n_adv = 3;
`else
        n_adv = 256;
`endif
        for (int k = 1; k <= n_adv; k++) begin
            sense(1'b1, 1'b0, 1'b0);
            tick();
            finish_move();
`ifdef NAV_STEP_LIMIT_EN
            if (k == 2) expect_out("budget_pre", 1'b0, 3'b001, 8'd2, 1'b1, 1'b0, 1'b0);
            if (k == 3) expect_out("budget_hit", 1'b0, 3'b001, 8'd3, 1'b0, 1'b0, 1'b1);
`else
            if (k == 1)   expect_out("corr_first", 1'b0, 3'b001, 8'd1, 1'b1, 1'b0, 1'b0);
            if (k == 255) expect_out("sat_reach", 1'b0, 3'b001, 8'd255, 1'b1, 1'b0, 1'b0);
            if (k == 256) expect_out("sat_hold", 1'b0, 3'b001, 8'd255, 1'b1, 1'b0, 1'b0);
`endif
        end

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clockc3);
        @(posedge clockc3);
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations never compared", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
